// File: rtl/ifu_iccm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_iccm_arb_pkg
// Description : Shared types and parameter defaults for the ICCM
//               fetch/DMA arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_iccm_arb_pkg;

  // Arbiter ownership states; encodings are fixed so debug views stay stable.
  typedef enum logic [1:0] {
    FETCH = 2'b00,
    DRAIN = 2'b01,
    DMA   = 2'b10
  } arb_state_e;

  localparam int AW_DEFAULT            = 14;
  localparam int STARVE_LIMIT_DEFAULT  = 8;
  localparam int DMA_MAX_BURST_DEFAULT = 4;
  localparam int CNT_W                 = 4;

endpackage
`default_nettype wire

// File: rtl/ifu_iccm_arb_satcnt.sv
`default_nettype none
// ============================================================================
// Module      : ifu_iccm_arb_satcnt
// Description : 4-bit up counter that sticks at all-ones; clear wins over
//               increment.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_iccm_arb_satcnt
  import ifu_iccm_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, otherwise count up until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ifu_iccm_arb_ctl.sv
`default_nettype none
// ============================================================================
// Module      : ifu_iccm_arb_ctl
// Description : Arbitrates the single ICCM SRAM port between instruction
//               fetch (normal priority winner) and DMA, with a starvation
//               escape that drains fetch and hands DMA a bounded burst.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_iccm_arb_ctl
  import ifu_iccm_arb_pkg::*;
#(
  parameter int AW            = AW_DEFAULT,
  parameter int STARVE_LIMIT  = STARVE_LIMIT_DEFAULT,
  parameter int DMA_MAX_BURST = DMA_MAX_BURST_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifc_req,
  input  logic [AW-1:0] ifc_addr,
  output logic          ifc_gnt,
  output logic          ifc_rsp_valid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [63:0]   dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rsp_valid,
  input  logic          flush,
  output logic          iccm_rden,
  output logic          iccm_wren,
  output logic [AW-1:0] iccm_addr,
  output logic [63:0]   iccm_wdata,
  input  logic [63:0]   iccm_rdata,
  output logic [63:0]   rsp_rdata,
  output logic          dma_iccm_stall_any
);

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic             w_ifc_gnt;
  logic             w_dma_gnt;
  logic [CNT_W-1:0] w_starve_cnt;
  logic [CNT_W-1:0] w_burst_cnt;
  logic             w_burst_last;
  logic             w_dma_exit;
  logic             ifc_rsp_q;
  logic             dma_rsp_q;

  // This grant completes the allowed DMA burst.
  assign w_burst_last = w_dma_gnt && (w_burst_cnt == CNT_W'(DMA_MAX_BURST - 1));
  // DMA ownership ends when the requester goes away or the burst is used up.
  assign w_dma_exit   = (state_q == DMA) && (!dma_req || w_burst_last);

  // Grant selection and state transitions.
  always_comb begin
    w_ifc_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    state_d   = state_q;
    unique case (state_q)
      FETCH: begin
        w_ifc_gnt = ifc_req;
        w_dma_gnt = dma_req && !ifc_req;
        if (dma_req && !w_dma_gnt &&
            (w_starve_cnt == CNT_W'(STARVE_LIMIT - 1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DMA;
      end
      DMA: begin
        w_dma_gnt = dma_req;
        if (w_dma_exit) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Cycles DMA has been kept waiting while requesting.
  ifu_iccm_arb_satcnt u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (dma_req && !w_dma_gnt),
    .clr_i (w_dma_gnt || !dma_req || w_dma_exit),
    .cnt_o (w_starve_cnt)
  );

  // Beats granted during the current forced DMA ownership.
  ifu_iccm_arb_satcnt u_burst_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i ((state_q == DMA) && w_dma_gnt),
    .clr_i (w_dma_exit),
    .cnt_o (w_burst_cnt)
  );

  // One-cycle read response tracking; flush only cancels the fetch side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifc_rsp_q <= 1'b0;
      dma_rsp_q <= 1'b0;
    end else begin
      ifc_rsp_q <= w_ifc_gnt && !flush;
      dma_rsp_q <= w_dma_gnt && !dma_we;
    end
  end

  // Grants are held low while reset is applied.
  assign ifc_gnt = w_ifc_gnt && !rst;
  assign dma_gnt = w_dma_gnt && !rst;

  assign ifc_rsp_valid      = ifc_rsp_q && !flush;
  assign dma_rsp_valid      = dma_rsp_q;
  assign rsp_rdata          = iccm_rdata;
  assign dma_iccm_stall_any = (state_q == DRAIN) || (state_q == DMA);

  // SRAM port steering from whichever requester holds the grant.
  assign iccm_rden  = ifc_gnt || (dma_gnt && !dma_we);
  assign iccm_wren  = dma_gnt && dma_we;
  assign iccm_addr  = ifc_gnt ? ifc_addr : (dma_gnt ? dma_addr : '0);
  assign iccm_wdata = dma_gnt ? dma_wdata : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_ifu_iccm_arb_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_iccm_arb_ctl
// Description : Directed self-checking bench for ifu_iccm_arb_ctl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_iccm_arb_ctl;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifc_req;
  logic [AW-1:0] ifc_addr;
  logic          ifc_gnt;
  logic          ifc_rsp_valid;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [63:0]   dma_wdata;
  logic          dma_gnt;
  logic          dma_rsp_valid;
  logic          flush;
  logic          iccm_rden;
  logic          iccm_wren;
  logic [AW-1:0] iccm_addr;
  logic [63:0]   iccm_wdata;
  logic [63:0]   iccm_rdata;
  logic [63:0]   rsp_rdata;
  logic          stall;

  int total = 0;
  int bad   = 0;

  ifu_iccm_arb_ctl #(.AW(AW), .STARVE_LIMIT(8), .DMA_MAX_BURST(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .ifc_req            (ifc_req),
    .ifc_addr           (ifc_addr),
    .ifc_gnt            (ifc_gnt),
    .ifc_rsp_valid      (ifc_rsp_valid),
    .dma_req            (dma_req),
    .dma_we             (dma_we),
    .dma_addr           (dma_addr),
    .dma_wdata          (dma_wdata),
    .dma_gnt            (dma_gnt),
    .dma_rsp_valid      (dma_rsp_valid),
    .flush              (flush),
    .iccm_rden          (iccm_rden),
    .iccm_wren          (iccm_wren),
    .iccm_addr          (iccm_addr),
    .iccm_wdata         (iccm_wdata),
    .iccm_rdata         (iccm_rdata),
    .rsp_rdata          (rsp_rdata),
    .dma_iccm_stall_any (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Both requesters must never hold a grant in the same cycle.
  always @(negedge clk) begin
    total++;
    assert (!(ifc_gnt && dma_gnt)) else begin
      bad++;
      $error("FAIL mutex observed=%b%b expected=not both", ifc_gnt, dma_gnt);
    end
  end

  initial begin
    rst = 1'b1; ifc_req = 1'b1; ifc_addr = '0; dma_req = 1'b1; dma_we = 1'b0;
    dma_addr = '0; dma_wdata = '0; flush = 1'b0; iccm_rdata = 64'h0;

    // Outputs quiet while reset is held, even with both requests up.
    mid();
    chk("rst_ifc_gnt", ifc_gnt, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rden", iccm_rden, 0);
    tick();
    mid();
    chk("rst_ifc_rsp", ifc_rsp_valid, 0);
    chk("rst_dma_rsp", dma_rsp_valid, 0);
    tick();

    // Fetch only.
    rst = 1'b0; dma_req = 1'b0; ifc_req = 1'b1; ifc_addr = 14'h10;
    mid();
    chk("f_ifc_gnt", ifc_gnt, 1);
    chk("f_rden", iccm_rden, 1);
    chk("f_wren", iccm_wren, 0);
    chk("f_addr", iccm_addr, 14'h10);
    chk("f_wdata", iccm_wdata, 0);
    chk("f_rsp_first", ifc_rsp_valid, 0);
    tick();
    ifc_req = 1'b0; iccm_rdata = 64'hDEAD_BEEF_0123_4567;
    mid();
    chk("f_rsp", ifc_rsp_valid, 1);
    chk("f_rdata", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
    chk("f_idle_addr", iccm_addr, 0);
    chk("f_idle_rden", iccm_rden, 0);
    tick();

    // Idle steal by a DMA write.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 14'h20; dma_wdata = 64'hA5A5_5A5A_0F0F_F0F0;
    mid();
    chk("w_dma_gnt", dma_gnt, 1);
    chk("w_wren", iccm_wren, 1);
    chk("w_rden", iccm_rden, 0);
    chk("w_addr", iccm_addr, 14'h20);
    chk("w_wdata", iccm_wdata, 64'hA5A5_5A5A_0F0F_F0F0);
    chk("w_stall", stall, 0);
    tick();
    dma_req = 1'b0; dma_we = 1'b0;
    mid();
    chk("w_no_rsp", dma_rsp_valid, 0);
    chk("w_stall2", stall, 0);
    tick();

    // Flush: fetch granted at N, flush at N+1 with a DMA read granted.
    ifc_req = 1'b1; ifc_addr = 14'h12;
    mid();
    chk("fl_ifc_gnt", ifc_gnt, 1);
    tick();
    ifc_req = 1'b0; flush = 1'b1; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 14'h40;
    mid();
    chk("fl_ifc_rsp", ifc_rsp_valid, 0);
    chk("fl_dma_gnt", dma_gnt, 1);
    chk("fl_addr", iccm_addr, 14'h40);
    tick();
    flush = 1'b0; dma_req = 1'b0;
    mid();
    chk("fl_dma_rsp", dma_rsp_valid, 1);
    chk("fl_ifc_rsp2", ifc_rsp_valid, 0);
    tick();
    // Fetch granted while flush is up yields no response.
    ifc_req = 1'b1; flush = 1'b1;
    mid();
    chk("fl_gnt_same", ifc_gnt, 1);
    tick();
    ifc_req = 1'b0; flush = 1'b0;
    mid();
    chk("fl_rsp_same", ifc_rsp_valid, 0);
    tick();

    // Starvation: both requests held continuously.
    ifc_req = 1'b1; ifc_addr = 14'h11; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 14'h30;
    for (int i = 0; i < 8; i++) begin
      mid();
      chk($sformatf("s1_wait%0d_dgnt", i), dma_gnt, 0);
      chk($sformatf("s1_wait%0d_igAs", i), ifc_gnt, 1);
      chk($sformatf("s1_wait%0d_stall", i), stall, 0);
      tick();
    end
    mid();
    chk("s1_drain_stall", stall, 1);
    chk("s1_drain_igt", ifc_gnt, 0);
    chk("s1_drain_dgt", dma_gnt, 0);
    chk("s1_drain_rden", iccm_rden, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      mid();
      chk($sformatf("s1_beat%0d_dgnt", i), dma_gnt, 1);
      chk($sformatf("s1_beat%0d_igt", i), ifc_gnt, 0);
      chk($sformatf("s1_beat%0d_stall", i), stall, 1);
      chk($sformatf("s1_beat%0d_addr", i), iccm_addr, 14'h30);
      chk($sformatf("s1_beat%0d_rsp", i), dma_rsp_valid, (i == 0) ? 1'b0 : 1'b1);
      tick();
    end
    mid();
    chk("s1_back_stall", stall, 0);
    chk("s1_back_igt", ifc_gnt, 1);
    chk("s1_back_dgt", dma_gnt, 0);
    chk("s1_back_rsp", dma_rsp_valid, 1);
    chk("s1_back_addr", iccm_addr, 14'h11);
    tick();

    // Second round repeats, then DMA drops after two beats.
    for (int i = 0; i < 7; i++) begin
      mid();
      chk($sformatf("s2_wait%0d_dgnt", i), dma_gnt, 0);
      tick();
    end
    mid();
    chk("s2_drain_stall", stall, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      mid();
      chk($sformatf("s2_beat%0d_dgnt", i), dma_gnt, 1);
      tick();
    end
    dma_req = 1'b0;
    mid();
    chk("e_dma_hold_stall", stall, 1);
    chk("e_dma_hold_igt", ifc_gnt, 0);
    chk("e_dma_hold_dgt", dma_gnt, 0);
    tick();
    dma_req = 1'b1;
    mid();
    chk("e_fetch_stall", stall, 0);
    chk("e_fetch_igt", ifc_gnt, 1);
    chk("e_fetch_dgt", dma_gnt, 0);
    tick();
    // Cleared counters: a full wait and a full four-beat burst again.
    for (int i = 0; i < 7; i++) begin
      mid();
      chk($sformatf("s3_wait%0d_dgnt", i), dma_gnt, 0);
      chk($sformatf("s3_wait%0d_stall", i), stall, 0);
      tick();
    end
    mid();
    chk("s3_drain_stall", stall, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      mid();
      chk($sformatf("s3_beat%0d_dgnt", i), dma_gnt, 1);
      tick();
    end
    mid();
    chk("s3_back_stall", stall, 0);
    chk("s3_back_igt", ifc_gnt, 1);
    tick();

    // Reset after one DMA beat abandons the burst.
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    mid();
    chk("r_drain_stall", stall, 1);
    tick();
    mid();
    chk("r_beat_dgnt", dma_gnt, 1);
    rst = 1'b1;
    mid();
    chk("r_rst_stall", stall, 0);
    chk("r_rst_rsp", dma_rsp_valid, 0);
    chk("r_rst_dgnt", dma_gnt, 0);
    chk("r_rst_igt", ifc_gnt, 0);
    tick();
    rst = 1'b0;
    mid();
    chk("r_after_stall", stall, 0);
    chk("r_after_rsp", dma_rsp_valid, 0);
    chk("r_after_igt", ifc_gnt, 1);
    chk("r_after_dgt", dma_gnt, 0);
    tick();
    ifc_req = 1'b0; dma_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifu_iccm_arb_ctl.md
IFU_ICCM_ARB_CTL -- requirements
Module: ifu_iccm_arb_ctl

Interface
REQ-001 SHALL have parameter AW, default 14, ICCM word-address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, max cycles a DMA request waits before forced ownership; legal range 2..15.
REQ-003 SHALL have parameter DMA_MAX_BURST, default 4, max DMA beats per forced ownership; legal range 1..15.
REQ-004 SHALL have port: clk  in  1  sole clock.
REQ-005 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port: ifc_req  in  1  fetch read request.
REQ-007 SHALL have port: ifc_addr  in  AW  fetch word address.
REQ-008 SHALL have port: ifc_gnt  out  1  fetch request accepted this cycle.
REQ-009 SHALL have port: ifc_rsp_valid  out  1  fetch read data valid on rsp_rdata.
REQ-010 SHALL have port: dma_req  in  1  DMA request.
REQ-011 SHALL have port: dma_we  in  1  DMA write (1) / read (0).
REQ-012 SHALL have port: dma_addr  in  AW  DMA word address.
REQ-013 SHALL have port: dma_wdata  in  64  DMA write data.
REQ-014 SHALL have port: dma_gnt  out  1  DMA request accepted this cycle.
REQ-015 SHALL have port: dma_rsp_valid  out  1  DMA read data valid on rsp_rdata.
REQ-016 SHALL have port: flush  in  1  pipeline flush; cancels fetch responses.
REQ-017 SHALL have ports: iccm_rden/iccm_wren  out  1 each; iccm_addr  out  AW; iccm_wdata  out  64  SRAM port.
REQ-018 SHALL have ports: iccm_rdata  in  64; rsp_rdata  out  64 (rsp_rdata = iccm_rdata, passthrough).
REQ-019 SHALL have port: dma_iccm_stall_any  out  1  forces fetch pipe to stall.

Function
REQ-020 SHALL implement FSM states FETCH, DRAIN, DMA; reset state FETCH.
REQ-021 FETCH: ifc_gnt = ifc_req; dma_gnt = dma_req & ~ifc_req (fetch wins simultaneous requests).
REQ-022 Starve counter (4 bit): increments when dma_req & ~dma_gnt; clears when dma_gnt or ~dma_req; saturates at 15.
REQ-023 FETCH -> DRAIN when dma_req & ~dma_gnt & starve counter == STARVE_LIMIT-1.
REQ-024 DRAIN: no grants, stall asserted, unconditional -> DMA next cycle.
REQ-025 DMA: dma_gnt = dma_req; ifc_gnt = 0; burst counter increments per dma_gnt.
REQ-026 DMA -> FETCH when ~dma_req, or when the grant making burst count == DMA_MAX_BURST occurs; counters clear on exit.
REQ-027 dma_iccm_stall_any = 1 exactly when state is DRAIN or DMA (driven from state flops, no input path).
REQ-028 SRAM mux: iccm_rden = ifc_gnt | (dma_gnt & ~dma_we); iccm_wren = dma_gnt & dma_we; iccm_addr/iccm_wdata from granted requester, all zero when no grant.
REQ-029 ifc_gnt and dma_gnt SHALL never both be 1 in one cycle.
REQ-030 Read latency 1: ifc_rsp_valid = registered(ifc_gnt & ~flush) & ~flush; dma_rsp_valid = registered(dma_gnt & ~dma_we).
REQ-031 Flush SHALL not affect DMA grants, DMA responses, FSM or counters.
REQ-032 DMA writes produce no response.

Reset
REQ-033 On rst: state FETCH, both counters 0, response flops 0; all outputs 0 while rst asserted and first cycle after, except grants following REQ-021 from cycle after deassertion.
REQ-034 Reset mid-DMA-burst SHALL abandon the burst with no response issued.

Structure
REQ-035 Package ifu_iccm_arb_pkg SHALL hold the state enum (FETCH=2'b00, DRAIN=2'b01, DMA=2'b10) and parameter defaults.
REQ-036 One sub-module ifu_iccm_arb_satcnt (4-bit saturating counter, inc/clr) SHALL be instantiated twice (starve, burst).

Verification
REQ-037 Fetch only: ifc_req=1 addr 0x10 -> ifc_gnt=1, iccm_rden=1, ifc_rsp_valid=1 next cycle with rsp_rdata=iccm_rdata.
REQ-038 Idle steal: ifc_req=0, dma_req=1 write 0x20 -> dma_gnt=1, iccm_wren=1 same cycle, no response, stall stays 0.
REQ-039 Starvation: ifc_req=1 and dma_req=1 continuously -> dma_gnt=0 for 8 cycles, DRAIN on cycle 9 (stall=1, no grants), DMA grants 4 beats, then FETCH, repeating.
REQ-040 Flush: ifc_gnt at cycle N, flush=1 at N+1 -> ifc_rsp_valid=0 at N+1; DMA read granted at N+1 still gives dma_rsp_valid at N+2.
REQ-041 Early burst end: in DMA, dma_req drops after 2 beats -> FETCH next cycle, stall=0, counters 0.
REQ-042 Reset in DMA after 1 beat -> state FETCH, stall=0, no dma_rsp_valid; assertion ifc_gnt & dma_gnt never true throughout.
